demux_1to4_buffered: RTL and testbench

//  Registered 1-to-4 demultiplexer with valid/ready handshake: one WIDTH-bit source is steered
//  by a 2-bit select into one of four one-deep output slots. Write-side counterpart of the
//  4-to-1 operand mux; routes ALU/bus results to four destination units (register-file bank,

---
 rtl/demux_1to4_buffered_pkg.sv | 17 +
 rtl/demux_1to4_buffered_slot.sv | 45 ++++
 rtl/demux_1to4_buffered.sv | 64 ++++++
 tb/tb_demux_1to4_buffered.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/demux_1to4_buffered_pkg.sv
// rtl/demux_1to4_buffered_pkg.sv - shared constants and select decode for the 1-to-4 demux
//
// Purpose: channel count, select width and default word width, shared with the
//          4-to-1 operand mux, plus a select-to-one-hot helper.
// Ports:   none (package)
package demux_1to4_buffered_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  localparam int WORD_W = 24;

  function automatic logic [NUM_CH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    sel_onehot      = '0;
    sel_onehot[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/demux_1to4_buffered_slot.sv
// rtl/demux_1to4_buffered_slot.sv - one-deep output slot (data register + full flag)
//
// Purpose: holds one word for a single destination until its sink drains it.
// Ports:
//   Clock      in   1      rising-edge clock
//   Reset      in   1      synchronous, active-high; clears full and data
//   load       in   1      capture din this cycle (already qualified by accept)
//   din        in   WIDTH  word to capture
//   sink_ready in   1      downstream sink accepts this cycle
//   data       out  WIDTH  slot contents
//   full       out  1      slot holds a word
//   ready      out  1      slot can take a word this cycle
module demux_slot
  import demux_1to4_buffered_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             sink_ready,
  output logic [WIDTH-1:0] data,
  output logic             full,
  output logic             ready
);

  // Pass-through ready: a full slot still accepts when it is draining this cycle.
  assign ready = ~full | sink_ready;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      full <= 1'b0;
      data <= '0;
    end else if (load) begin
      // Load wins over a same-cycle drain: the slot stays full with the new word.
      full <= 1'b1;
      data <= din;
    end else if (full && sink_ready) begin
      // Data deliberately left unchanged on drain.
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1to4_buffered.sv
// rtl/demux_1to4_buffered.sv - registered 1-to-4 demultiplexer with valid/ready handshake
//
// Purpose: steers one source word by a 2-bit select into one of four one-deep
//          output slots that each drain independently.
// Ports:
//   Clock        in   1      rising-edge clock
//   Reset        in   1      synchronous, active-high
//   Hyrja        in   WIDTH  input data word
//   S            in   2      destination select 0..3
//   HyrjaValid   in   1      source offers Hyrja/S
//   HyrjaReady   out  1      block accepts this cycle (combinational)
//   Dalja0..3    out  WIDTH  per-channel slot data
//   DaljaValid   out  4      per-channel slot full
//   DaljaReady   in   4      per-channel sink accepts
module demux_1to4_buffered
  import demux_1to4_buffered_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [WIDTH-1:0]  Hyrja,
  input  logic [SEL_W-1:0]  S,
  input  logic              HyrjaValid,
  output logic              HyrjaReady,
  output logic [WIDTH-1:0]  Dalja0,
  output logic [WIDTH-1:0]  Dalja1,
  output logic [WIDTH-1:0]  Dalja2,
  output logic [WIDTH-1:0]  Dalja3,
  output logic [NUM_CH-1:0] DaljaValid,
  input  logic [NUM_CH-1:0] DaljaReady
);

  logic [NUM_CH-1:0] load;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] slot_ready;
  logic [WIDTH-1:0]  slot_data [NUM_CH];
  logic              acc;

  // Ready depends only on the selected slot, never on HyrjaValid.
  assign HyrjaReady = slot_ready[S];
  assign acc        = HyrjaValid & HyrjaReady;
  assign load       = {NUM_CH{acc}} & sel_onehot(S);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .Clock      (Clock),
      .Reset      (Reset),
      .load       (load[i]),
      .din        (Hyrja),
      .sink_ready (DaljaReady[i]),
      .data       (slot_data[i]),
      .full       (full[i]),
      .ready      (slot_ready[i])
    );
  end

  assign DaljaValid = full;
  assign Dalja0     = slot_data[0];
  assign Dalja1     = slot_data[1];
  assign Dalja2     = slot_data[2];
  assign Dalja3     = slot_data[3];

endmodule

// File: tb/tb_demux_1to4_buffered.sv
// tb/tb_demux_1to4_buffered.sv - self-checking bench for demux_1to4_buffered
module tb_demux_1to4_buffered;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [23:0] Hyrja;
  logic [1:0]  S;
  logic        HyrjaValid;
  logic        HyrjaReady;
  logic [23:0] Dalja0, Dalja1, Dalja2, Dalja3;
  logic [3:0]  DaljaValid;
  logic [3:0]  DaljaReady;

  demux_1to4_buffered #(.WIDTH(24)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Hyrja      (Hyrja),
    .S          (S),
    .HyrjaValid (HyrjaValid),
    .HyrjaReady (HyrjaReady),
    .Dalja0     (Dalja0),
    .Dalja1     (Dalja1),
    .Dalja2     (Dalja2),
    .Dalja3     (Dalja3),
    .DaljaValid (DaljaValid),
    .DaljaReady (DaljaReady)
  );

  always #5 Clock = ~Clock;

  logic [23:0] dq [4];
  always_comb begin
    dq[0] = Dalja0;
    dq[1] = Dalja1;
    dq[2] = Dalja2;
    dq[3] = Dalja3;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // e_ch 0..3 checks that channel's data; e_ch 4 checks all four channels equal e_dat.
  typedef struct {
    logic        rst;
    logic        vld;
    logic [1:0]  s;
    logic [23:0] w;
    logic [3:0]  drdy;
    logic        chk;
    logic        e_rdy;
    logic [3:0]  e_val;
    logic [2:0]  e_ch;
    logic [23:0] e_dat;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic vld, input logic [1:0] s, input logic [23:0] w,
                     input logic [3:0] drdy, input logic c, input logic e_rdy,
                     input logic [3:0] e_val, input logic [2:0] e_ch, input logic [23:0] e_dat);
    tbl.push_back('{rst, vld, s, w, drdy, c, e_rdy, e_val, e_ch, e_dat});
  endtask

  task automatic drive(input logic rst, input logic vld, input logic [1:0] s,
                       input logic [23:0] w, input logic [3:0] drdy);
    Reset      = rst;
    HyrjaValid = vld;
    S          = s;
    Hyrja      = w;
    DaljaReady = drdy;
  endtask

  // Reference model: one bounded queue (capacity 1) per destination plus traffic counters.
  logic [23:0] mq [4][$];
  int          acc_cnt [4];
  int          drn_cnt [4];

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      mq[i].delete();
      acc_cnt[i] = 0;
      drn_cnt[i] = 0;
    end
  endtask

  initial begin
    logic        stalled;
    logic        exp_rdy;
    logic [3:0]  exp_val;
    logic        r_rst, r_vld;
    logic [1:0]  r_s;
    logic [23:0] r_w;
    logic [3:0]  r_drdy;

    //   rst vld s  word       drdy  chk rdy val      ch dat
    // Reset held with a valid offer to ch2
    add(1, 1, 2, 24'hAAAAAA, 4'hF, 0, 0, 4'b0000, 4, 24'h0);
    add(1, 1, 2, 24'hAAAAAA, 4'hF, 1, 1, 4'b0000, 4, 24'h0);
    add(0, 0, 2, 24'h000000, 4'hF, 1, 1, 4'b0000, 4, 24'h0);
    // Single route to ch2
    add(0, 1, 2, 24'hABCDEF, 4'hF, 1, 1, 4'b0000, 2, 24'h0);
    add(0, 0, 2, 24'h000000, 4'hF, 1, 1, 4'b0100, 2, 24'hABCDEF);
    add(0, 0, 2, 24'h000000, 4'hF, 1, 1, 4'b0000, 2, 24'hABCDEF);
    // Backpressure on ch1
    add(0, 1, 1, 24'h000111, 4'hD, 1, 1, 4'b0000, 1, 24'h0);
    add(0, 1, 1, 24'h000222, 4'hD, 1, 0, 4'b0010, 1, 24'h000111);
    add(0, 1, 1, 24'h000222, 4'hD, 1, 0, 4'b0010, 1, 24'h000111);
    add(0, 1, 1, 24'h000222, 4'hF, 1, 1, 4'b0010, 1, 24'h000111);
    add(0, 0, 1, 24'h000000, 4'hD, 1, 0, 4'b0010, 1, 24'h000222);
    add(0, 0, 1, 24'h000000, 4'hF, 1, 1, 4'b0010, 1, 24'h000222);
    add(0, 0, 0, 24'h000000, 4'hF, 1, 1, 4'b0000, 1, 24'h000222);
    // Simultaneous drain and refill on ch3
    add(0, 1, 3, 24'h123456, 4'h7, 1, 1, 4'b0000, 3, 24'h0);
    add(0, 1, 3, 24'h654321, 4'hF, 1, 1, 4'b1000, 3, 24'h123456);
    add(0, 0, 3, 24'h000000, 4'h7, 1, 0, 4'b1000, 3, 24'h654321);
    add(0, 0, 3, 24'h000000, 4'hF, 1, 1, 4'b1000, 3, 24'h654321);
    // Independence: ch0 stalled full, others stream
    add(0, 1, 0, 24'h0000AA, 4'hE, 1, 1, 4'b0000, 0, 24'h0);
    add(0, 1, 1, 24'h000001, 4'hE, 1, 1, 4'b0001, 0, 24'h0000AA);
    add(0, 1, 2, 24'h000002, 4'hE, 1, 1, 4'b0011, 1, 24'h000001);
    add(0, 1, 3, 24'h000003, 4'hE, 1, 1, 4'b0101, 2, 24'h000002);
    add(0, 1, 0, 24'h0000BB, 4'hE, 1, 0, 4'b1001, 3, 24'h000003);
    add(0, 0, 0, 24'h000000, 4'hE, 1, 0, 4'b0001, 0, 24'h0000AA);
    // Fill all four, then reset mid-operation
    add(0, 1, 1, 24'h000011, 4'h0, 1, 1, 4'b0001, 0, 24'h0000AA);
    add(0, 1, 2, 24'h000022, 4'h0, 1, 1, 4'b0011, 1, 24'h000011);
    add(0, 1, 3, 24'h000033, 4'h0, 1, 1, 4'b0111, 2, 24'h000022);
    add(1, 1, 0, 24'h000044, 4'h0, 1, 0, 4'b1111, 3, 24'h000033);
    add(0, 1, 0, 24'h000055, 4'h0, 1, 1, 4'b0000, 4, 24'h0);
    add(0, 0, 0, 24'h000000, 4'h0, 1, 0, 4'b0001, 0, 24'h000055);
    add(0, 0, 0, 24'h000000, 4'hF, 1, 1, 4'b0001, 0, 24'h000055);

    for (int r = 0; r < tbl.size(); r++) begin
      drive(tbl[r].rst, tbl[r].vld, tbl[r].s, tbl[r].w, tbl[r].drdy);
      #4;
      if (tbl[r].chk) begin
        chk($sformatf("row%0d_ready", r), {23'd0, HyrjaReady}, {23'd0, tbl[r].e_rdy});
        chk($sformatf("row%0d_valid", r), {20'd0, DaljaValid}, {20'd0, tbl[r].e_val});
        if (tbl[r].e_ch == 3'd4) begin
          for (int i = 0; i < 4; i++)
            chk($sformatf("row%0d_data%0d", r, i), dq[i], tbl[r].e_dat);
        end else begin
          chk($sformatf("row%0d_data%0d", r, tbl[r].e_ch), dq[tbl[r].e_ch[1:0]], tbl[r].e_dat);
        end
      end
      @(posedge Clock);
      #1;
    end

    // Randomized phase against the queue model, starting from a fresh reset.
    drive(1, 0, 0, 24'h0, 4'h0);
    @(posedge Clock);
    #1;
    model_clear();
    stalled = 1'b0;
    r_vld = 1'b0; r_s = 2'd0; r_w = 24'd0;
    for (int n = 0; n < 3000; n++) begin
      if (!stalled) begin
        r_vld = ($urandom_range(0, 3) != 0);
        r_s   = 2'($urandom_range(0, 3));
        r_w   = 24'($urandom);
      end
      r_drdy = 4'($urandom);
      r_rst  = ($urandom_range(0, 150) == 0);
      drive(r_rst, r_vld, r_s, r_w, r_drdy);
      #4;
      exp_rdy = (mq[r_s].size() == 0) || r_drdy[r_s];
      for (int i = 0; i < 4; i++) exp_val[i] = (mq[i].size() != 0);
      chk($sformatf("rnd%0d_ready", n), {23'd0, HyrjaReady}, {23'd0, exp_rdy});
      chk($sformatf("rnd%0d_valid", n), {20'd0, DaljaValid}, {20'd0, exp_val});
      for (int i = 0; i < 4; i++) begin
        if (mq[i].size() != 0)
          chk($sformatf("rnd%0d_data%0d", n, i), dq[i], mq[i][0]);
        if (n % 16 == 0)
          chk($sformatf("rnd%0d_balance%0d", n, i), {23'd0, DaljaValid[i]},
              24'(acc_cnt[i] - drn_cnt[i]));
      end
      @(posedge Clock);
      #1;
      if (r_rst) begin
        model_clear();
        stalled = 1'b0;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (mq[i].size() != 0 && r_drdy[i]) begin
            void'(mq[i].pop_front());
            drn_cnt[i]++;
          end
        end
        if (r_vld && exp_rdy) begin
          mq[r_s].push_back(r_w);
          acc_cnt[r_s]++;
        end
        stalled = r_vld && !exp_rdy;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
